jtag_tap_ctrl: RTL

IEEE 1149.1 TAP controller and instruction decoder for the RISC-V debug transport. It sits directly upstream of the DTM/DMI shift logic of the JTAG-to-AXI-lite bridge. It runs the 16-state TAP FSM on `tck_i` and holds the instruction register, IDCODE and BYPASS data registers. It emits `capture`/`shift`/`update` strobes plus DTMCS/DMI select lines, and multiplexes the downstream TDO bits onto the pad.

---
 rtl/jtag_tap_pkg.sv | 41 ++++
 rtl/jtag_tap_fsm.sv | 79 +++++++
 rtl/jtag_tap_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/jtag_tap_pkg.sv
// Shared types for the JTAG TAP controller: TAP states, instruction codes and
// the IR capture pattern.
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    TestLogicReset,
    RunTestIdle,
    SelectDrScan,
    CaptureDr,
    ShiftDr,
    Exit1Dr,
    PauseDr,
    Exit2Dr,
    UpdateDr,
    SelectIrScan,
    CaptureIr,
    ShiftIr,
    Exit1Ir,
    PauseIr,
    Exit2Ir,
    UpdateIr
  } tap_state_e;

  typedef enum logic [4:0] {
    BYPASS0   = 5'h00,
    IDCODE    = 5'h01,
    DTMCSR    = 5'h10,
    DMIACCESS = 5'h11,
    BYPASS1   = 5'h1F
  } ir_e;

  typedef enum logic [1:0] {
    SelBypass,
    SelIdcode,
    SelDtmcs,
    SelDmi
  } dr_sel_e;

  localparam logic [4:0] IrCapture = 5'b00101;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 16-state TAP state machine; emits one-cycle state decodes used
// as capture/shift/update strobes by the register logic.
module jtag_tap_fsm (
  input  logic tck_i,
  input  logic trst_ni,
  input  logic tms_i,
  output logic test_logic_reset_o,
  output logic capture_dr_o,
  output logic shift_dr_o,
  output logic update_dr_o,
  output logic capture_ir_o,
  output logic shift_ir_o,
  output logic update_ir_o
);
  import jtag_tap_pkg::*;

  tap_state_e state_q, state_d;

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q <= TestLogicReset;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    test_logic_reset_o  = 1'b0;
    capture_dr_o        = 1'b0;
    shift_dr_o          = 1'b0;
    update_dr_o         = 1'b0;
    capture_ir_o        = 1'b0;
    shift_ir_o          = 1'b0;
    update_ir_o         = 1'b0;

    case (state_q)
      TestLogicReset: begin
        test_logic_reset_o = 1'b1;
        state_d = tms_i ? TestLogicReset : RunTestIdle;
      end
      RunTestIdle:  state_d = tms_i ? SelectDrScan : RunTestIdle;
      SelectDrScan: state_d = tms_i ? SelectIrScan : CaptureDr;
      CaptureDr: begin
        capture_dr_o = 1'b1;
        state_d = tms_i ? Exit1Dr : ShiftDr;
      end
      ShiftDr: begin
        shift_dr_o = 1'b1;
        state_d = tms_i ? Exit1Dr : ShiftDr;
      end
      Exit1Dr:  state_d = tms_i ? UpdateDr : PauseDr;
      PauseDr:  state_d = tms_i ? Exit2Dr : PauseDr;
      Exit2Dr:  state_d = tms_i ? UpdateDr : ShiftDr;
      UpdateDr: begin
        update_dr_o = 1'b1;
        state_d = tms_i ? SelectDrScan : RunTestIdle;
      end
      SelectIrScan: state_d = tms_i ? TestLogicReset : CaptureIr;
      CaptureIr: begin
        capture_ir_o = 1'b1;
        state_d = tms_i ? Exit1Ir : ShiftIr;
      end
      ShiftIr: begin
        shift_ir_o = 1'b1;
        state_d = tms_i ? Exit1Ir : ShiftIr;
      end
      Exit1Ir:  state_d = tms_i ? UpdateIr : PauseIr;
      PauseIr:  state_d = tms_i ? Exit2Ir : PauseIr;
      Exit2Ir:  state_d = tms_i ? UpdateIr : ShiftIr;
      UpdateIr: begin
        update_ir_o = 1'b1;
        state_d = tms_i ? SelectDrScan : RunTestIdle;
      end
      default: state_d = TestLogicReset;
    endcase
  end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller top: IR, IDCODE/BYPASS data registers, instruction decode and
// TDO mux. Define JTAG_TAP_IDCODE_EN to include the IDCODE instruction/register.
module jtag_tap_ctrl #(
  parameter int unsigned IrLength    = 5,
  parameter logic [31:0] IdcodeValue = 32'h00000DB3
) (
  input  logic tck_i,
  input  logic trst_ni,
  input  logic tms_i,
  input  logic td_i,
  input  logic testmode_i,
  output logic td_o,
  output logic tdo_oe_o,
  output logic tck_o,
  output logic dmi_clear_o,
  output logic update_o,
  output logic capture_o,
  output logic shift_o,
  output logic tdi_o,
  output logic dtmcs_select_o,
  input  logic dtmcs_tdo_i,
  output logic dmi_select_o,
  input  logic dmi_tdo_i
);
  import jtag_tap_pkg::*;

  localparam logic [IrLength-1:0] IrCaptureVal = IrLength'(IrCapture);
  localparam logic [IrLength-1:0] IrDtmcs      = IrLength'(DTMCSR);
  localparam logic [IrLength-1:0] IrDmi        = IrLength'(DMIACCESS);
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IrLength-1:0] IrIdcode     = IrLength'(IDCODE);
  localparam logic [IrLength-1:0] IrResetVal   = IrIdcode;
`else
  localparam logic [IrLength-1:0] IrResetVal   = IrLength'(BYPASS1);
`endif

  logic tlr, capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir;

  jtag_tap_fsm u_fsm (
    .tck_i              (tck_i),
    .trst_ni            (trst_ni),
    .tms_i              (tms_i),
    .test_logic_reset_o (tlr),
    .capture_dr_o       (capture_dr),
    .shift_dr_o         (shift_dr),
    .update_dr_o        (update_dr),
    .capture_ir_o       (capture_ir),
    .shift_ir_o         (shift_ir),
    .update_ir_o        (update_ir)
  );

  logic [IrLength-1:0] ir_q, ir_d;
  logic [IrLength-1:0] ir_shift_q, ir_shift_d;
  logic                bypass_q, bypass_d;
  logic                td_q, td_d;
  logic                tdo_oe_q, tdo_oe_d;
  dr_sel_e             dr_sel;

  // Unknown codes, including both all-zeros and all-ones, fall through to BYPASS.
  always_comb begin
    dr_sel = SelBypass;
    if (ir_q == IrDtmcs) begin
      dr_sel = SelDtmcs;
    end else if (ir_q == IrDmi) begin
      dr_sel = SelDmi;
`ifdef JTAG_TAP_IDCODE_EN
    end else if (ir_q == IrIdcode) begin
      dr_sel = SelIdcode;
`endif
    end
  end

  always_comb begin
    ir_shift_d = ir_shift_q;
    if (capture_ir) begin
      ir_shift_d = IrCaptureVal;
    end else if (shift_ir) begin
      ir_shift_d = {td_i, ir_shift_q[IrLength-1:1]};
    end

    ir_d = ir_q;
    if (tlr) begin
      ir_d = IrResetVal;
    end else if (update_ir) begin
      ir_d = ir_shift_q;
    end

    bypass_d = bypass_q;
    if (dr_sel == SelBypass) begin
      if (capture_dr) begin
        bypass_d = 1'b0;
      end else if (shift_dr) begin
        bypass_d = td_i;
      end
    end
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      ir_q       <= IrResetVal;
      ir_shift_q <= '0;
      bypass_q   <= 1'b0;
    end else begin
      ir_q       <= ir_d;
      ir_shift_q <= ir_shift_d;
      bypass_q   <= bypass_d;
    end
  end

`ifdef JTAG_TAP_IDCODE_EN
  logic [31:0] idcode_q, idcode_d;

  always_comb begin
    idcode_d = idcode_q;
    if (dr_sel == SelIdcode) begin
      if (capture_dr) begin
        idcode_d = IdcodeValue;
      end else if (shift_dr) begin
        idcode_d = {td_i, idcode_q[31:1]};
      end
    end
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      idcode_q <= '0;
    end else begin
      idcode_q <= idcode_d;
    end
  end
`else
  logic unused_idcode;
  assign unused_idcode = ^IdcodeValue;
`endif

  always_comb begin
    td_d     = 1'b0;
    tdo_oe_d = shift_ir | shift_dr;
    if (shift_ir) begin
      td_d = ir_shift_q[0];
    end else if (shift_dr) begin
      case (dr_sel)
        SelDtmcs:  td_d = dtmcs_tdo_i;
        SelDmi:    td_d = dmi_tdo_i;
`ifdef JTAG_TAP_IDCODE_EN
        SelIdcode: td_d = idcode_q[0];
`endif
        default:   td_d = bypass_q;
      endcase
    end
  end

  // TDO launches on the falling edge; scan mode keeps all flops on the true clock.
  logic tck_tdo;
  assign tck_tdo = testmode_i ? tck_i : ~tck_i;

  always_ff @(posedge tck_tdo or negedge trst_ni) begin
    if (!trst_ni) begin
      td_q     <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      td_q     <= td_d;
      tdo_oe_q <= tdo_oe_d;
    end
  end

  assign td_o           = td_q;
  assign tdo_oe_o       = tdo_oe_q;
  assign tck_o          = tck_i;
  assign tdi_o          = td_i;
  assign dmi_clear_o    = tlr;
  assign capture_o      = capture_dr;
  assign shift_o        = shift_dr;
  assign update_o       = update_dr;
  assign dtmcs_select_o = (dr_sel == SelDtmcs);
  assign dmi_select_o   = (dr_sel == SelDmi);

endmodule
